// File: rtl/hilo_pkg.sv
// hilo_pkg: shared constants and stage-entry field layout for the HI/LO unit.
// An entry is {valid, we_hi, we_lo, hi, lo}; valid is kept beside the payload.
package hilo_pkg;

    localparam int HILO_WIDTH = 32;

    // Payload layout, MSB to LSB: {we_hi, we_lo, hi[W-1:0], lo[W-1:0]}
    function automatic int hilo_pay_w(input int w);
        return 2 * w + 2;
    endfunction

    function automatic int hilo_we_hi_bit(input int w);
        return 2 * w + 1;
    endfunction

    function automatic int hilo_we_lo_bit(input int w);
        return 2 * w;
    endfunction

    function automatic int hilo_hi_lsb(input int w);
        return w;
    endfunction

endpackage

// File: rtl/hilo_stage_reg.sv
// hilo_stage_reg: one shadow stage (valid + payload) with hold, kill, async clear.
// Ports: clk/rst, i_hold (keep contents), i_kill (clear valid, beats hold),
//        i_valid/i_pay (next entry when advancing), o_valid/o_pay (current entry).
module hilo_stage_reg
    import hilo_pkg::*;
#(
    parameter int WIDTH = HILO_WIDTH
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 i_hold,
    input  logic                 i_kill,
    input  logic                 i_valid,
    input  logic [2*WIDTH+1:0]   i_pay,
    output logic                 o_valid,
    output logic [2*WIDTH+1:0]   o_pay
);

    logic               r_valid;
    logic [2*WIDTH+1:0] r_pay;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_valid <= 1'b0;
            r_pay   <= '0;
        end else if (i_hold) begin
            // Payload stays put; a kill still drops the entry
            r_valid <= r_valid & ~i_kill;
        end else begin
            r_valid <= i_valid;
            r_pay   <= i_pay;
        end
    end

    assign o_valid = r_valid;
    assign o_pay   = r_pay;

endmodule

// File: rtl/hilo_unit.sv
// hilo_unit: architectural HI/LO with MEM/WB shadow stages and EX forwarding.
// Ports: EX write request (ex_*), pipe_stall, mem_flush; rd_hi/rd_lo forwarded
//        reads, hi_q/lo_q architectural values, pending = any shadow entry valid.
module hilo_unit
    import hilo_pkg::*;
#(
    parameter int WIDTH = HILO_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ex_valid,
    input  logic             ex_we_hi,
    input  logic             ex_we_lo,
    input  logic [WIDTH-1:0] ex_hi_data,
    input  logic [WIDTH-1:0] ex_lo_data,
    input  logic             pipe_stall,
    input  logic             mem_flush,
    output logic [WIDTH-1:0] rd_hi,
    output logic [WIDTH-1:0] rd_lo,
    output logic [WIDTH-1:0] hi_q,
    output logic [WIDTH-1:0] lo_q,
    output logic             pending
);

    localparam int PW   = hilo_pay_w(WIDTH);
    localparam int WEH  = hilo_we_hi_bit(WIDTH);
    localparam int WEL  = hilo_we_lo_bit(WIDTH);
    localparam int HLSB = hilo_hi_lsb(WIDTH);

    logic             w_issue;
    logic [PW-1:0]    w_ex_pay;
    logic             w_m_valid;
    logic [PW-1:0]    w_m_pay;
    logic             w_w_valid;
    logic [PW-1:0]    w_w_pay;
    logic             w_m_we_hi;
    logic             w_m_we_lo;
    logic [WIDTH-1:0] w_m_hi;
    logic [WIDTH-1:0] w_m_lo;
    logic             w_w_we_hi;
    logic             w_w_we_lo;
    logic [WIDTH-1:0] w_w_hi;
    logic [WIDTH-1:0] w_w_lo;
    logic [WIDTH-1:0] r_hi;
    logic [WIDTH-1:0] r_lo;

    assign w_issue  = ex_valid & (ex_we_hi | ex_we_lo) & ~mem_flush;
    assign w_ex_pay = {ex_we_hi, ex_we_lo, ex_hi_data, ex_lo_data};

    hilo_stage_reg #(.WIDTH(WIDTH)) u_m (
        .clk     (clk),
        .rst     (rst),
        .i_hold  (pipe_stall),
        .i_kill  (mem_flush),
        .i_valid (w_issue),
        .i_pay   (w_ex_pay),
        .o_valid (w_m_valid),
        .o_pay   (w_m_pay)
    );

    // W is past the exception point: never killed, flush only blocks M->W
    hilo_stage_reg #(.WIDTH(WIDTH)) u_w (
        .clk     (clk),
        .rst     (rst),
        .i_hold  (pipe_stall),
        .i_kill  (1'b0),
        .i_valid (w_m_valid & ~mem_flush),
        .i_pay   (w_m_pay),
        .o_valid (w_w_valid),
        .o_pay   (w_w_pay)
    );

    assign w_m_we_hi = w_m_pay[WEH];
    assign w_m_we_lo = w_m_pay[WEL];
    assign w_m_hi    = w_m_pay[HLSB +: WIDTH];
    assign w_m_lo    = w_m_pay[0 +: WIDTH];
    assign w_w_we_hi = w_w_pay[WEH];
    assign w_w_we_lo = w_w_pay[WEL];
    assign w_w_hi    = w_w_pay[HLSB +: WIDTH];
    assign w_w_lo    = w_w_pay[0 +: WIDTH];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_hi <= '0;
            r_lo <= '0;
        end else if (!pipe_stall && w_w_valid) begin
            if (w_w_we_hi) r_hi <= w_w_hi;
            if (w_w_we_lo) r_lo <= w_w_lo;
        end
    end

    // Youngest producer wins, each half resolved on its own
    always_comb begin
        rd_hi = r_hi;
        rd_lo = r_lo;
        if (w_m_valid && w_m_we_hi)
            rd_hi = w_m_hi;
        else if (w_w_valid && w_w_we_hi)
            rd_hi = w_w_hi;
        if (w_m_valid && w_m_we_lo)
            rd_lo = w_m_lo;
        else if (w_w_valid && w_w_we_lo)
            rd_lo = w_w_lo;
    end

    assign hi_q    = r_hi;
    assign lo_q    = r_lo;
    assign pending = w_m_valid | w_w_valid;

endmodule

// File: tb/tb_hilo_unit.sv
// tb_hilo_unit: directed scenarios plus randomized traffic against
// an age-tracked list-of-pending-writes reference model.
module tb_hilo_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        ex_valid;
    logic        ex_we_hi;
    logic        ex_we_lo;
    logic [31:0] ex_hi_data;
    logic [31:0] ex_lo_data;
    logic        pipe_stall;
    logic        mem_flush;
    logic [31:0] rd_hi;
    logic [31:0] rd_lo;
    logic [31:0] hi_q;
    logic [31:0] lo_q;
    logic        pending;

    int total = 0;
    int bad   = 0;

    hilo_unit #(.WIDTH(32)) dut (
        .clk        (clk),
        .rst        (rst),
        .ex_valid   (ex_valid),
        .ex_we_hi   (ex_we_hi),
        .ex_we_lo   (ex_we_lo),
        .ex_hi_data (ex_hi_data),
        .ex_lo_data (ex_lo_data),
        .pipe_stall (pipe_stall),
        .mem_flush  (mem_flush),
        .rd_hi      (rd_hi),
        .rd_lo      (rd_lo),
        .hi_q       (hi_q),
        .lo_q       (lo_q),
        .pending    (pending)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        wh;
        logic        wl;
        logic [31:0] h;
        logic [31:0] l;
        int          age;
    } ent_t;

    ent_t        q[$];
    logic [31:0] m_hi;
    logic [31:0] m_lo;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        q.delete();
        m_hi = '0;
        m_lo = '0;
    endtask

    // age 1 = sitting in MEM, age 2 = sitting in WB
    task automatic model_edge();
        ent_t e;
        if (mem_flush) begin
            for (int i = q.size() - 1; i >= 0; i--)
                if (q[i].age == 1) q.delete(i);
        end
        if (!pipe_stall) begin
            if (q.size() > 0 && q[0].age == 2) begin
                if (q[0].wh) m_hi = q[0].h;
                if (q[0].wl) m_lo = q[0].l;
                void'(q.pop_front());
            end
            foreach (q[i]) q[i].age++;
            if (ex_valid && (ex_we_hi || ex_we_lo) && !mem_flush) begin
                e.wh  = ex_we_hi;
                e.wl  = ex_we_lo;
                e.h   = ex_hi_data;
                e.l   = ex_lo_data;
                e.age = 1;
                q.push_back(e);
            end
        end
    endtask

    task automatic check_all(input string tag);
        logic [31:0] eh;
        logic [31:0] el;
        eh = m_hi;
        el = m_lo;
        foreach (q[i]) begin
            if (q[i].wh) eh = q[i].h;
            if (q[i].wl) el = q[i].l;
        end
        chk({tag, ".hi_q"}, hi_q, m_hi);
        chk({tag, ".lo_q"}, lo_q, m_lo);
        chk({tag, ".rd_hi"}, rd_hi, eh);
        chk({tag, ".rd_lo"}, rd_lo, el);
        chk({tag, ".pend"}, {31'd0, pending}, {31'd0, q.size() > 0});
    endtask

    task automatic cyc(input logic v, input logic wh, input logic wl,
                       input logic [31:0] h, input logic [31:0] l,
                       input logic st, input logic fl);
        ex_valid   = v;
        ex_we_hi   = wh;
        ex_we_lo   = wl;
        ex_hi_data = h;
        ex_lo_data = l;
        pipe_stall = st;
        mem_flush  = fl;
        @(posedge clk);
        model_edge();
        #1;
        check_all("mdl");
    endtask

    task automatic idle();
        cyc(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    endtask

    initial begin
        rst = 1'b1;
        ex_valid = 0; ex_we_hi = 0; ex_we_lo = 0;
        ex_hi_data = 0; ex_lo_data = 0;
        pipe_stall = 0; mem_flush = 0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_all("rst0");
        rst = 1'b0;

        // 1: reset while a MULT sits in MEM
        cyc(1'b1, 1'b1, 1'b1, 32'h1, 32'h2, 1'b0, 1'b0);
        chk("t1_pend_pre", {31'd0, pending}, 32'd1);
        #2;
        rst = 1'b1;
        model_reset();
        #1;
        chk("t1_hi", hi_q, 32'h0);
        chk("t1_lo", lo_q, 32'h0);
        chk("t1_rdhi", rd_hi, 32'h0);
        chk("t1_rdlo", rd_lo, 32'h0);
        chk("t1_pend", {31'd0, pending}, 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // 2: MULT, no stall
        cyc(1'b1, 1'b1, 1'b1, 32'hFFFF_FFFF, 32'h1, 1'b0, 1'b0);
        chk("t2_rdhi_m", rd_hi, 32'hFFFF_FFFF);
        idle();
        chk("t2_rdhi_w", rd_hi, 32'hFFFF_FFFF);
        chk("t2_hi_early", hi_q, 32'h0);
        idle();
        chk("t2_hi", hi_q, 32'hFFFF_FFFF);
        chk("t2_lo", lo_q, 32'h1);

        // 3: MTHI then MTLO
        cyc(1'b1, 1'b1, 1'b0, 32'hAAAA_0000, 32'h0, 1'b0, 1'b0);
        cyc(1'b1, 1'b0, 1'b1, 32'h0, 32'h0000_BBBB, 1'b0, 1'b0);
        chk("t3_rdhi", rd_hi, 32'hAAAA_0000);
        chk("t3_rdlo", rd_lo, 32'h0000_BBBB);
        idle();
        idle();
        chk("t3_hi", hi_q, 32'hAAAA_0000);
        chk("t3_lo", lo_q, 32'h0000_BBBB);

        // 4: DIV in MEM flushed, same-cycle EX write dropped
        cyc(1'b1, 1'b1, 1'b1, 32'h3, 32'h5, 1'b0, 1'b0);
        chk("t4_rdhi_m", rd_hi, 32'h3);
        cyc(1'b1, 1'b1, 1'b1, 32'h9, 32'h9, 1'b0, 1'b1);
        chk("t4_pend", {31'd0, pending}, 32'd0);
        chk("t4_rdhi", rd_hi, 32'hAAAA_0000);
        idle();
        idle();
        chk("t4_hi", hi_q, 32'hAAAA_0000);
        chk("t4_lo", lo_q, 32'h0000_BBBB);

        // 5: stall with entries in both stages
        cyc(1'b1, 1'b0, 1'b1, 32'h0, 32'h20, 1'b0, 1'b0);
        cyc(1'b1, 1'b0, 1'b1, 32'h0, 32'h10, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) begin
            cyc(1'b1, 1'b1, 1'b1, 32'h77, 32'h77, 1'b1, 1'b0);
            chk("t5_lo_hold", lo_q, 32'h0000_BBBB);
            chk("t5_rdlo", rd_lo, 32'h10);
        end
        idle();
        chk("t5_lo_e1", lo_q, 32'h20);
        idle();
        chk("t5_lo_e2", lo_q, 32'h10);

        // 6: stall + flush together
        cyc(1'b1, 1'b0, 1'b1, 32'h0, 32'h8, 1'b0, 1'b0);
        cyc(1'b1, 1'b0, 1'b1, 32'h0, 32'h7, 1'b0, 1'b0);
        cyc(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b1);
        chk("t6_pend", {31'd0, pending}, 32'd1);
        chk("t6_rdlo", rd_lo, 32'h8);
        chk("t6_lo_hold", lo_q, 32'h10);
        for (int i = 0; i < 3; i++) begin
            idle();
            chk("t6_lo", lo_q, 32'h8);
        end

        // random traffic
        for (int i = 0; i < 400; i++) begin
            cyc($urandom_range(0, 3) != 0, 1'($urandom), 1'($urandom),
                $urandom, $urandom,
                $urandom_range(0, 4) == 0, $urandom_range(0, 9) == 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
